// File: rtl/itr_pkg.sv
// Shared configuration, types and helpers for the multi-source interrupt controller.
package itr_pkg;

  // Controller configuration; index 0 is the highest priority source.
  localparam int NITR    = 4;
  localparam int MINSTW  = 9;
  localparam int ITRBASE = 0;
  localparam int VSTEP   = 4;
  localparam int NEST    = 2;

  // Level width must also encode the idle level NITR.
  localparam int LW = $clog2(NITR + 1);
  // Depth counter must reach NEST.
  localparam int DW = $clog2(NEST + 1);

  localparam logic [LW-1:0] LVL_IDLE = LW'(NITR);

  // One nesting-stack entry: return address plus the level to restore.
  typedef struct packed {
    logic [MINSTW-1:0] addr;
    logic [LW-1:0]     lvl;
  } stk_entry_t;

  // Vector address of source i, truncated to the instruction address width.
  function automatic logic [MINSTW-1:0] vec_addr(input logic [LW-1:0] i);
    int v;
    v = ITRBASE + int'(i) * VSTEP;
    return v[MINSTW-1:0];
  endfunction

  // One-hot in-service pattern for a level; the idle level maps to all zeros.
  function automatic logic [NITR-1:0] lvl_onehot(input logic [LW-1:0] l);
    logic [NITR-1:0] oh;
    for (int k = 0; k < NITR; k++) begin
      oh[k] = (int'(l) == k);
    end
    return oh;
  endfunction

endpackage

// File: rtl/itr_stack.sv
// LIFO of NEST return entries. The caller never asserts push and pop together.
module itr_stack
  import itr_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  stk_entry_t    din,
  output stk_entry_t    top,
  output logic [DW-1:0] depth
);

  localparam int IW = (NEST > 1) ? $clog2(NEST) : 1;

  stk_entry_t       mem [NEST];
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;
  logic [DW-1:0]    depth_dec;

  assign depth_dec = depth - 1'b1;
  assign wr_idx    = IW'(depth);
  assign rd_idx    = IW'(depth_dec);
  // Top of stack is only meaningful while depth is non-zero.
  assign top       = mem[rd_idx];

  // Entry storage; contents need no reset because depth gates every read.
  always_ff @(posedge clk) begin
    if (push && (depth != DW'(NEST))) begin
      mem[wr_idx] <= din;
    end
  end

  // Occupancy counter, discarded immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth <= '0;
    end else if (push && (depth != DW'(NEST))) begin
      depth <= depth + 1'b1;
    end else if (pop && (depth != '0)) begin
      depth <= depth_dec;
    end
  end

endmodule

// File: rtl/itr_ctrl_multi.sv
// Prioritised, nested, vectored interrupt controller sitting in front of the pc load path.
module itr_ctrl_multi
  import itr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NITR-1:0]   itr_src,
  input  logic              mask_we,
  input  logic [NITR-1:0]   mask_in,
  input  logic [MINSTW-1:0] pc_addr,
  input  logic              boundary,
  input  logic              itr_ret,
  output logic              itr_take,
  output logic [MINSTW-1:0] itr_vec,
  output logic              ret_valid,
  output logic [MINSTW-1:0] ret_addr,
  output logic [NITR-1:0]   pending,
  output logic [NITR-1:0]   active,
  output logic [1:0]        err
);

  logic [NITR-1:0] sync1;
  logic [NITR-1:0] sync2;
  logic [NITR-1:0] dly;
  logic [NITR-1:0] edge_det;
  logic [NITR-1:0] mask;
  logic [NITR-1:0] req;
  logic [NITR-1:0] take_clr;
  logic [LW-1:0]   level;
  logic [LW-1:0]   cand_idx;
  logic            cand_valid;
  logic            take_go;
  logic            ret_go;
  logic [DW-1:0]   depth;
  stk_entry_t      stk_top;
  stk_entry_t      stk_din;

  assign edge_det = sync2 & ~dly;
  assign req      = pending & mask;

  // Lowest-index enabled pending source wins.
  always_comb begin
    cand_valid = 1'b0;
    cand_idx   = LVL_IDLE;
    for (int k = NITR - 1; k >= 0; k--) begin
      if (req[k]) begin
        cand_valid = 1'b1;
        cand_idx   = LW'(k);
      end
    end
  end

  // RETI has precedence; a take needs a boundary, higher priority and stack room.
  assign ret_go   = itr_ret && (depth != '0);
  assign take_go  = cand_valid && (cand_idx < level) && boundary &&
                    (depth != DW'(NEST)) && !itr_ret;
  assign take_clr = take_go ? lvl_onehot(cand_idx) : '0;
  assign stk_din  = '{addr: pc_addr, lvl: level};

  itr_stack u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (take_go),
    .pop   (ret_go),
    .din   (stk_din),
    .top   (stk_top),
    .depth (depth)
  );

  // Two-flop synchroniser plus a delay flop for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      dly   <= '0;
    end else begin
      sync1 <= itr_src;
      sync2 <= sync1;
      dly   <= sync2;
    end
  end

  // Mask, pending and sticky error state; a new edge beats a same-cycle take clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask    <= '0;
      pending <= '0;
      err     <= '0;
    end else begin
      if (mask_we) begin
        mask <= mask_in;
      end
      pending <= (pending & ~take_clr) | edge_det;
      if (itr_ret && (depth == '0)) begin
        err[0] <= 1'b1;
      end
      if (|(edge_det & pending & ~take_clr)) begin
        err[1] <= 1'b1;
      end
    end
  end

  // Take/return sequencing with registered one-cycle redirect pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level     <= LVL_IDLE;
      active    <= '0;
      itr_take  <= 1'b0;
      itr_vec   <= '0;
      ret_valid <= 1'b0;
      ret_addr  <= '0;
    end else if (ret_go) begin
      level     <= stk_top.lvl;
      active    <= lvl_onehot(stk_top.lvl);
      ret_valid <= 1'b1;
      ret_addr  <= stk_top.addr;
      itr_take  <= 1'b0;
      itr_vec   <= '0;
    end else if (take_go) begin
      level     <= cand_idx;
      active    <= lvl_onehot(cand_idx);
      itr_take  <= 1'b1;
      itr_vec   <= vec_addr(cand_idx);
      ret_valid <= 1'b0;
      ret_addr  <= '0;
    end else begin
      itr_take  <= 1'b0;
      itr_vec   <= '0;
      ret_valid <= 1'b0;
      ret_addr  <= '0;
    end
  end

endmodule

// File: tb/tb_itr_ctrl_multi.sv
// Directed bench for itr_ctrl_multi: single take, nesting, blocking, mask/boundary,
// depth limit, error flags and asynchronous reset.
module tb_itr_ctrl_multi;

  logic       clk;
  logic       rst;
  logic [3:0] itr_src;
  logic       mask_we;
  logic [3:0] mask_in;
  logic [8:0] pc_addr;
  logic       boundary;
  logic       itr_ret;
  logic       itr_take;
  logic [8:0] itr_vec;
  logic       ret_valid;
  logic [8:0] ret_addr;
  logic [3:0] pending;
  logic [3:0] active;
  logic [1:0] err;

  int checks   = 0;
  int failures = 0;

  itr_ctrl_multi dut (
    .clk       (clk),
    .rst       (rst),
    .itr_src   (itr_src),
    .mask_we   (mask_we),
    .mask_in   (mask_in),
    .pc_addr   (pc_addr),
    .boundary  (boundary),
    .itr_ret   (itr_ret),
    .itr_take  (itr_take),
    .itr_vec   (itr_vec),
    .ret_valid (ret_valid),
    .ret_addr  (ret_addr),
    .pending   (pending),
    .active    (active),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Single-cycle pulse on one source; pending is set after the third edge.
  task automatic pulse(input int i);
    itr_src[i] = 1'b1;
    tick();
    itr_src[i] = 1'b0;
    tick();
    tick();
  endtask

  task automatic set_mask(input logic [3:0] m);
    mask_we = 1'b1;
    mask_in = m;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic reti();
    itr_ret = 1'b1;
    tick();
    itr_ret = 1'b0;
  endtask

  initial begin
    rst = 1'b1; itr_src = '0; mask_we = 1'b0; mask_in = '0;
    pc_addr = '0; boundary = 1'b0; itr_ret = 1'b0;
    tick(); tick();
    chk("rst_take",    {15'd0, itr_take}, 16'h0);
    chk("rst_pending", {12'd0, pending},  16'h0);
    chk("rst_active",  {12'd0, active},   16'h0);
    chk("rst_err",     {14'd0, err},      16'h0);
    rst = 1'b0;
    tick();

    // Single source take.
    set_mask(4'b1111);
    boundary = 1'b1;
    pc_addr  = 9'h010;
    itr_src[2] = 1'b1; tick();
    itr_src[2] = 1'b0; tick();
    chk("single_pend_e1", {12'd0, pending}, 16'h0);
    tick();
    chk("single_pend_e2", {12'd0, pending}, 16'h4);
    chk("single_notake_e2", {15'd0, itr_take}, 16'h0);
    tick();
    chk("single_take", {15'd0, itr_take}, 16'h1);
    chk("single_vec",  {7'd0, itr_vec},   16'h8);
    chk("single_act",  {12'd0, active},   16'h4);
    chk("single_clr",  {12'd0, pending},  16'h0);
    tick();
    chk("single_pulse_end", {15'd0, itr_take}, 16'h0);

    // Nesting: source 0 preempts source 2.
    pc_addr = 9'h055;
    pulse(0);
    chk("nest_pend", {12'd0, pending}, 16'h1);
    tick();
    chk("nest_take", {15'd0, itr_take}, 16'h1);
    chk("nest_vec",  {7'd0, itr_vec},   16'h0);
    chk("nest_act",  {12'd0, active},   16'h1);
    tick();
    reti();
    chk("nest_ret1_v",  {15'd0, ret_valid}, 16'h1);
    chk("nest_ret1_a",  {7'd0, ret_addr},   16'h55);
    chk("nest_ret1_act",{12'd0, active},    16'h4);
    chk("nest_ret1_tk", {15'd0, itr_take},  16'h0);
    tick();
    chk("nest_ret_end", {15'd0, ret_valid}, 16'h0);
    reti();
    chk("nest_ret2_a",  {7'd0, ret_addr},   16'h10);
    chk("nest_ret2_act",{12'd0, active},    16'h0);
    tick();

    // Blocking: lower priority source waits until RETI.
    pc_addr = 9'h020;
    pulse(1);
    tick();
    chk("blk_take1", {12'd0, active}, 16'h2);
    pulse(3);
    chk("blk_pend3", {12'd0, pending}, 16'h8);
    tick();
    chk("blk_notake", {15'd0, itr_take}, 16'h0);
    chk("blk_held",   {12'd0, pending},  16'h8);
    reti();
    chk("blk_ret_v",  {15'd0, ret_valid}, 16'h1);
    chk("blk_ret_a",  {7'd0, ret_addr},   16'h20);
    chk("blk_ret_tk", {15'd0, itr_take},  16'h0);
    tick();
    chk("blk_take3", {15'd0, itr_take}, 16'h1);
    chk("blk_vec3",  {7'd0, itr_vec},   16'hc);
    chk("blk_act3",  {12'd0, active},   16'h8);
    reti();
    tick();

    // Mask and boundary gating.
    set_mask(4'b0000);
    pulse(1);
    tick();
    chk("msk_notake", {15'd0, itr_take}, 16'h0);
    chk("msk_pend",   {12'd0, pending},  16'h2);
    boundary = 1'b0;
    set_mask(4'b1111);
    tick();
    chk("bnd_notake", {15'd0, itr_take}, 16'h0);
    chk("bnd_pend",   {12'd0, pending},  16'h2);
    boundary = 1'b1;
    tick();
    chk("bnd_take", {15'd0, itr_take}, 16'h1);
    chk("bnd_vec",  {7'd0, itr_vec},   16'h4);
    reti();
    tick();

    // Depth limit with NEST=2, then RETI racing a candidate.
    pc_addr = 9'h030;
    pulse(3);
    tick();
    chk("dep_take3", {7'd0, itr_vec}, 16'hc);
    pc_addr = 9'h031;
    pulse(1);
    tick();
    chk("dep_take1", {7'd0, itr_vec}, 16'h4);
    pulse(0);
    tick();
    chk("dep_notake", {15'd0, itr_take}, 16'h0);
    chk("dep_held",   {12'd0, pending},  16'h1);
    reti();
    chk("dep_race_ret", {15'd0, ret_valid}, 16'h1);
    chk("dep_race_tk",  {15'd0, itr_take},  16'h0);
    chk("dep_race_act", {12'd0, active},    16'h8);
    tick();
    chk("dep_late_tk",  {15'd0, itr_take}, 16'h1);
    chk("dep_late_vec", {7'd0, itr_vec},   16'h0);
    chk("dep_late_act", {12'd0, active},   16'h1);
    itr_ret = 1'b1;
    tick();
    chk("dep_pop1_a",   {7'd0, ret_addr}, 16'h31);
    chk("dep_pop1_act", {12'd0, active},  16'h8);
    tick();
    chk("dep_pop2_a",   {7'd0, ret_addr}, 16'h30);
    chk("dep_pop2_act", {12'd0, active},  16'h0);
    itr_ret = 1'b0;
    tick();
    chk("err_clean", {14'd0, err}, 16'h0);

    // Error flags.
    reti();
    chk("err_idle_reti", {14'd0, err},       16'h1);
    chk("err_idle_nov",  {15'd0, ret_valid}, 16'h0);
    boundary = 1'b0;
    pulse(2);
    pulse(2);
    chk("err_double",  {14'd0, err},     16'h3);
    chk("err_dbl_pend",{12'd0, pending}, 16'h4);
    boundary = 1'b1;
    tick();
    chk("err_take2", {12'd0, active}, 16'h4);

    // Asynchronous reset mid-service.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_take",    {15'd0, itr_take}, 16'h0);
    chk("arst_vec",     {7'd0, itr_vec},   16'h0);
    chk("arst_active",  {12'd0, active},   16'h0);
    chk("arst_pending", {12'd0, pending},  16'h0);
    chk("arst_err",     {14'd0, err},      16'h0);
    tick();
    rst = 1'b0;
    tick();
    reti();
    chk("arst_stack_empty", {15'd0, ret_valid}, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
